// File: rtl/instr_fetch.sv
// instr_fetch: PC owner and req/ack instruction fetch with retire counter and misaligned-target fault.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        pc_src,
  input  logic [31:0] pc_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] retired,
  output logic        fault
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;
  state_t state, state_next;
  logic retire;
  logic misaligned;
  logic [31:0] pc_next;
  assign pc_plus4 = pc + 32'd4;
  assign imem_addr = pc;
  assign retire = state == HOLD && instr_ready;
  assign pc_next = pc_src ? pc_target : pc_plus4;
  assign misaligned = |pc_next[1:0];
  always_comb begin
    state_next = state;
    state_next = state == IDLE ? FETCH :
                 state == FETCH && imem_ack ? HOLD :
                 retire ? (misaligned ? HALT : FETCH) : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      instr <= 32'h0000_0013;
      instr_valid <= 1'b0;
      imem_req <= 1'b0;
      retired <= 32'd0;
      fault <= 1'b0;
    end else begin
      state <= state_next;
      imem_req <= state_next == FETCH;
      if (state == FETCH && imem_ack) begin
        instr <= imem_rdata;
        instr_valid <= 1'b1;
      end
      if (retire) begin
        retired <= retired + 32'd1;
        instr_valid <= 1'b0;
        if (misaligned) fault <= 1'b1;
        else pc <= pc_next;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed stimulus; retire-time scoreboard checks pc/instr of every retired instruction.
module tb_instr_fetch;
  logic clk = 0, rst = 1;
  logic imem_req, imem_ack = 0, instr_valid, instr_ready = 1, pc_src = 0, fault;
  logic [31:0] imem_addr, imem_rdata = 0, instr, pc_target = 0, pc, pc_plus4, retired;
  logic rst2 = 1, req2, ack2 = 0, valid2, fault2;
  logic [31:0] addr2, rdata2 = 0, instr2, pc2, pc_plus4_2, retired2;
  logic ack_en = 1;
  int total = 0, bad = 0;
  logic [63:0] q[$];
  instr_fetch dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc_src(pc_src), .pc_target(pc_target), .pc(pc), .pc_plus4(pc_plus4), .retired(retired), .fault(fault)
  );
  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst2), .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2),
    .imem_rdata(rdata2), .instr(instr2), .instr_valid(valid2), .instr_ready(1'b1),
    .pc_src(1'b0), .pc_target(32'd0), .pc(pc2), .pc_plus4(pc_plus4_2), .retired(retired2), .fault(fault2)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[11:0], 20'h00013};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic seq(input logic [31:0] a);
    chk("fetch_addr", imem_addr, a);
    chk("fetch_req", {31'd0, imem_req}, 1);
    q.push_back({a, mem(a)});
    step();
    chk("hold_valid", {31'd0, instr_valid}, 1);
    chk("hold_instr", instr, mem(a));
    chk("hold_req", {31'd0, imem_req}, 0);
    chk("pc_plus4", pc_plus4, a + 32'd4);
    step();
  endtask
  // Memory for dut: 3 wait states at 0x10, zero-wait elsewhere; ack_en can stall it.
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      #2;
      if (imem_req && ack_en) begin
        imem_ack = cnt >= (imem_addr == 32'h10 ? 3 : 0);
        cnt++;
      end else begin
        imem_ack = 0;
        cnt = 0;
      end
      imem_rdata = mem(imem_addr);
    end
  end
  initial forever begin
    @(negedge clk);
    #2;
    ack2 = req2;
    rdata2 = mem(addr2);
  end
  initial forever begin
    @(negedge clk);
    #1;
    if (!rst && instr_valid && instr_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_retire: got pc %h expected no retire", pc);
      end else begin
        logic [63:0] e;
        e = q.pop_front();
        chk("retire_pc", pc, e[63:32]);
        chk("retire_instr", instr, e[31:0]);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    @(negedge clk);
    step();
    chk("rst_pc", pc, 0);
    chk("rst_instr", instr, 32'h13);
    chk("rst_valid", {31'd0, instr_valid}, 0);
    chk("rst_req", {31'd0, imem_req}, 0);
    chk("rst_retired", retired, 0);
    chk("rst_fault", {31'd0, fault}, 0);
    rst = 0;
    step();
    seq(0); seq(4); seq(8);
    chk("retired3", retired, 3);
    seq(32'hC);
    q.push_back({32'h10, mem(32'h10)});
    for (int k = 0; k < 4; k++) begin
      chk("wait_req", {31'd0, imem_req}, 1);
      chk("wait_addr", imem_addr, 32'h10);
      chk("wait_valid", {31'd0, instr_valid}, 0);
      step();
    end
    chk("wait_done_valid", {31'd0, instr_valid}, 1);
    chk("wait_done_instr", instr, mem(32'h10));
    step();
    seq(32'h14); seq(32'h18); seq(32'h1C);
    chk("seq_addr_20", imem_addr, 32'h20);
    q.push_back({32'h20, mem(32'h20)});
    step();
    chk("pc_plus4_20", pc_plus4, 32'h24);
    pc_src = 1;
    pc_target = 32'h100;
    step();
    pc_src = 0;
    pc_target = 0;
    chk("branch_addr", imem_addr, 32'h100);
    q.push_back({32'h100, mem(32'h100)});
    step();
    chk("branch_plus4", pc_plus4, 32'h104);
    step();
    chk("after_branch_addr", imem_addr, 32'h104);
    q.push_back({32'h104, mem(32'h104)});
    step();
    pc_src = 1;
    pc_target = 32'h102;
    step();
    pc_src = 0;
    pc_target = 0;
    chk("halt_fault", {31'd0, fault}, 1);
    chk("halt_pc", pc, 32'h104);
    chk("halt_req", {31'd0, imem_req}, 0);
    chk("halt_valid", {31'd0, instr_valid}, 0);
    chk("halt_instr", instr, mem(32'h104));
    chk("halt_retired", retired, 11);
    repeat (5) step();
    chk("halt_req_stay", {31'd0, imem_req}, 0);
    chk("halt_fault_stay", {31'd0, fault}, 1);
    chk("pending", q.size(), 0);
    rst = 1;
    step();
    chk("clr_fault", {31'd0, fault}, 0);
    chk("clr_pc", pc, 0);
    chk("clr_retired", retired, 0);
    chk("clr_instr", instr, 32'h13);
    rst = 0;
    step();
    chk("refetch_req", {31'd0, imem_req}, 1);
    chk("refetch_addr", imem_addr, 0);
    ack_en = 0;
    step();
    chk("stall_req", {31'd0, imem_req}, 1);
    rst = 1;
    ack_en = 1;
    step();
    chk("midfetch_req", {31'd0, imem_req}, 0);
    chk("midfetch_valid", {31'd0, instr_valid}, 0);
    chk("midfetch_pc", pc, 0);
    rst = 0;
    step();
    seq(0);
    chk("hold_retired1", retired, 1);
    chk("hold_fetch_addr", imem_addr, 4);
    instr_ready = 0;
    step();
    step();
    chk("hold_stall_valid", {31'd0, instr_valid}, 1);
    chk("hold_stall_pc", pc, 4);
    chk("hold_stall_retired", retired, 1);
    rst = 1;
    step();
    chk("midhold_valid", {31'd0, instr_valid}, 0);
    chk("midhold_pc", pc, 0);
    chk("midhold_retired", retired, 0);
    chk("midhold_req", {31'd0, imem_req}, 0);
    instr_ready = 1;
    rst2 = 0;
    step();
    chk("wrap_first_addr", addr2, 32'hFFFF_FFFC);
    chk("wrap_first_req", {31'd0, req2}, 1);
    step();
    chk("wrap_plus4", pc_plus4_2, 0);
    step();
    chk("wrap_second_addr", addr2, 0);
    chk("wrap_fault", {31'd0, fault2}, 0);
    chk("wrap_retired1", retired2, 1);
    step();
    force dut2.retired = 32'hFFFF_FFFF;
    #1;
    release dut2.retired;
    chk("forced_retired", retired2, 32'hFFFF_FFFF);
    step();
    chk("retired_wrap", retired2, 0);
    chk("wrap_third_addr", addr2, 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
